can_tx_mailbox_arbiter: RTL and testbench

- Schedules NUM_MB transmit mailboxes onto the single CAN transmit engine. Uses CAN priority: the lowest identifier wins.
- Latches mailbox requests and presents one frame at a time to the engine over a valid/ready handshake.
- Handles engine results: success, arbitration lost, or bus error. Manages retries, retry limits and aborts.
- Sits between the mailbox register file and the CAN TX bit engine, in the clk_can domain.

---
 rtl/can_tx_mailbox_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_can_tx_mailbox_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_mailbox_arbiter.sv
// CAN transmit mailbox arbiter: picks the lowest-identifier pending mailbox, offers it
// to the bit engine over valid/ready, and applies the success / retry / abort outcome.
module can_tx_mailbox_arbiter #(
  parameter int NUM_MB     = 4,
  parameter int ID_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_RETRY  = 15
) (
  input  logic                         clk_can,
  input  logic                         rst_n,
  input  logic [NUM_MB-1:0]            mb_req,
  input  logic [NUM_MB-1:0]            mb_abort,
  input  logic [NUM_MB*ID_WIDTH-1:0]   mb_id,
  input  logic [NUM_MB*DATA_WIDTH-1:0] mb_data,
  input  logic [NUM_MB*4-1:0]          mb_dlc,
  output logic [NUM_MB-1:0]            mb_done,
  output logic [NUM_MB-1:0]            mb_fail,
  output logic [NUM_MB-1:0]            mb_aborted,
  output logic [NUM_MB-1:0]            mb_pending,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [ID_WIDTH-1:0]          tx_id,
  output logic [DATA_WIDTH-1:0]        tx_data,
  output logic [3:0]                   tx_dlc,
  input  logic                         tx_result_valid,
  input  logic [1:0]                   tx_result,
  output logic                         busy,
  output logic [$clog2(NUM_MB)-1:0]    active_mb
);

  localparam int         IDX_W        = $clog2(NUM_MB);
  localparam logic [3:0] RETRY_LIMIT  = 4'(MAX_RETRY);
  localparam logic [1:0] RES_OK       = 2'b00;
  localparam logic [1:0] RES_ARB_LOST = 2'b01;

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, WAIT_RESULT} state_t;

  state_t                  state;
  logic [NUM_MB-1:0]       pending;
  logic [3:0]              retry_cnt [NUM_MB];
  logic                    abort_latched;

  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [ID_WIDTH-1:0]     win_id;
  logic [DATA_WIDTH-1:0]   win_data;
  logic [3:0]              win_dlc;
  logic [NUM_MB-1:0]       own;
  logic [NUM_MB-1:0]       side_abort;
  logic [NUM_MB-1:0]       req_set;
  logic                    abort_hit;
  logic [3:0]              retry_next;

  // Strict less-than keeps the earlier (lower-index) mailbox on identifier ties.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    win_id    = '0;
    win_data  = '0;
    win_dlc   = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending[i] && (!win_found || mb_id[i*ID_WIDTH +: ID_WIDTH] < win_id)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_id    = mb_id[i*ID_WIDTH +: ID_WIDTH];
        win_data  = mb_data[i*DATA_WIDTH +: DATA_WIDTH];
        win_dlc   = mb_dlc[i*4 +: 4];
      end
    end
  end

  // Mailbox the FSM currently owns; aborts to any other pending mailbox act at once.
  always_comb begin
    own = '0;
    case (state)
      SELECT:             if (win_found) own[win_idx] = 1'b1;
      ISSUE, WAIT_RESULT: own[active_mb] = 1'b1;
      default:            ;
    endcase
  end

  assign side_abort = mb_abort & pending & ~own;
  assign req_set    = mb_req & ~pending & ~mb_abort;
  assign abort_hit  = abort_latched | mb_abort[active_mb];
  assign retry_next = retry_cnt[active_mb] + 4'd1;

  assign mb_pending = pending;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk_can or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= '0;
      abort_latched <= 1'b0;
      tx_valid      <= 1'b0;
      tx_id         <= '0;
      tx_data       <= '0;
      tx_dlc        <= '0;
      active_mb     <= '0;
      mb_done       <= '0;
      mb_fail       <= '0;
      mb_aborted    <= '0;
      // NOTE: the retry counters decide when a mailbox fails, so they are reset like any
      // other state register instead of being treated as uninitialised storage.
      for (int i = 0; i < NUM_MB; i++) retry_cnt[i] <= '0;
    end else begin
      // NOTE: all state uses non-blocking assignment; a later per-bit write in this block
      // (e.g. pending[active_mb]) deliberately overrides the whole-vector default above it.
      mb_done    <= '0;
      mb_fail    <= '0;
      mb_aborted <= side_abort;
      pending    <= (pending | req_set) & ~side_abort;
      for (int i = 0; i < NUM_MB; i++)
        if (req_set[i]) retry_cnt[i] <= '0;

      case (state)
        IDLE: begin
          abort_latched <= 1'b0;
          if (|pending) state <= SELECT;
        end

        SELECT: begin
          if (!win_found) begin
            state <= IDLE;
          end else if (mb_abort[win_idx]) begin
            pending[win_idx]    <= 1'b0;
            mb_aborted[win_idx] <= 1'b1;
            state               <= IDLE;
          end else begin
            active_mb <= win_idx;
            tx_id     <= win_id;
            tx_data   <= win_data;
            tx_dlc    <= win_dlc;
            tx_valid  <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          // Acceptance wins over a same-cycle abort; that abort is deferred to the result.
          if (tx_ready) begin
            tx_valid      <= 1'b0;
            abort_latched <= mb_abort[active_mb];
            state         <= WAIT_RESULT;
          end else if (mb_abort[active_mb]) begin
            tx_valid              <= 1'b0;
            pending[active_mb]    <= 1'b0;
            mb_aborted[active_mb] <= 1'b1;
            state                 <= IDLE;
          end
        end

        WAIT_RESULT: begin
          if (tx_result_valid) begin
            abort_latched <= 1'b0;
            state         <= IDLE;
            if (tx_result == RES_OK) begin
              mb_done[active_mb] <= 1'b1;
              pending[active_mb] <= 1'b0;
            end else if (abort_hit) begin
              mb_aborted[active_mb] <= 1'b1;
              pending[active_mb]    <= 1'b0;
            end else if (tx_result != RES_ARB_LOST) begin
              retry_cnt[active_mb] <= retry_next;
              if (retry_next == RETRY_LIMIT) begin
                mb_fail[active_mb] <= 1'b1;
                pending[active_mb] <= 1'b0;
              end
            end
          end else if (mb_abort[active_mb]) begin
            abort_latched <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// Scoreboard bench for can_tx_mailbox_arbiter: the driver predicts frames and pulses from a
// mailbox-level model, a negedge monitor pops and compares whatever the DUT presents.
module tb_can_tx_mailbox_arbiter;

  localparam int NUM_MB = 4;
  localparam int IDW    = 32;
  localparam int DW     = 64;
  localparam int MAXR   = 3;

  logic                 clk_can;
  logic                 rst_n;
  logic [NUM_MB-1:0]    mb_req;
  logic [NUM_MB-1:0]    mb_abort;
  logic [NUM_MB*IDW-1:0] mb_id;
  logic [NUM_MB*DW-1:0] mb_data;
  logic [NUM_MB*4-1:0]  mb_dlc;
  logic [NUM_MB-1:0]    mb_done;
  logic [NUM_MB-1:0]    mb_fail;
  logic [NUM_MB-1:0]    mb_aborted;
  logic [NUM_MB-1:0]    mb_pending;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [IDW-1:0]       tx_id;
  logic [DW-1:0]        tx_data;
  logic [3:0]           tx_dlc;
  logic                 tx_result_valid;
  logic [1:0]           tx_result;
  logic                 busy;
  logic [1:0]           active_mb;

  can_tx_mailbox_arbiter #(
    .NUM_MB(NUM_MB), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .MAX_RETRY(MAXR)
  ) dut (
    .clk_can(clk_can), .rst_n(rst_n),
    .mb_req(mb_req), .mb_abort(mb_abort),
    .mb_id(mb_id), .mb_data(mb_data), .mb_dlc(mb_dlc),
    .mb_done(mb_done), .mb_fail(mb_fail), .mb_aborted(mb_aborted), .mb_pending(mb_pending),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_id(tx_id), .tx_data(tx_data), .tx_dlc(tx_dlc),
    .tx_result_valid(tx_result_valid), .tx_result(tx_result),
    .busy(busy), .active_mb(active_mb)
  );

  typedef struct {
    int             idx;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [3:0]     dlc;
  } frame_t;

  typedef struct {
    int         cyc;
    logic [3:0] done;
    logic [3:0] fail;
    logic [3:0] abrt;
  } pulse_t;

  frame_t exp_frames[$];
  pulse_t exp_pulses[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit stuck    = 0;

  // Mailbox-level reference model
  bit             m_pend [NUM_MB];
  int             m_rc   [NUM_MB];
  logic [IDW-1:0] m_id   [NUM_MB];
  logic [DW-1:0]  m_data [NUM_MB];
  logic [3:0]     m_dlc  [NUM_MB];
  int             m_act;
  bit             m_abort_l;

  initial begin
    clk_can = 1'b0;
    forever #5 clk_can = ~clk_can;
  end

  always @(posedge clk_can) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v = '0;
    for (int i = 0; i < NUM_MB; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Lowest identifier among pending mailboxes, lowest index on a tie; -1 if none.
  function automatic int m_winner();
    int best = -1;
    for (int i = 0; i < NUM_MB; i++)
      if (m_pend[i] && (best < 0 || m_id[i] < m_id[best])) best = i;
    return best;
  endfunction

  task automatic tick();
    @(posedge clk_can);
    #1;
  endtask

  task automatic load_mb(input int i, input logic [IDW-1:0] id, input logic [DW-1:0] data,
                         input logic [3:0] dlc);
    m_id[i] = id;  m_data[i] = data;  m_dlc[i] = dlc;
    mb_id[i*IDW +: IDW]  = id;
    mb_data[i*DW +: DW]  = data;
    mb_dlc[i*4 +: 4]     = dlc;
  endtask

  task automatic push_pulse(input logic [3:0] d, input logic [3:0] f, input logic [3:0] a);
    pulse_t p;
    p.cyc = cyc + 1;  p.done = d;  p.fail = f;  p.abrt = a;
    exp_pulses.push_back(p);
  endtask

  // Caller only sets abort bits on mailboxes that are not pending.
  task automatic request(input logic [3:0] req, input logic [3:0] abt);
    mb_req = req;  mb_abort = abt;
    for (int i = 0; i < NUM_MB; i++)
      if (req[i] && !abt[i] && !m_pend[i]) begin
        m_pend[i] = 1'b1;
        m_rc[i]   = 0;
      end
    tick();
    mb_req = '0;  mb_abort = '0;
    check("pending_after_req", mb_pending, m_pend_vec());
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      check("tx_valid_timeout", tx_valid, 1);
      stuck = 1'b1;
    end else if (m_winner() < 0) begin
      check("tx_valid_unexpected", tx_valid, 0);
      stuck = 1'b1;
      ok    = 1'b0;
    end
  endtask

  task automatic handshake(input int delay, input bit abort_same);
    bit     ok;
    frame_t f;
    wait_valid(ok);
    if (!ok) return;
    m_act  = m_winner();
    f.idx  = m_act;  f.id = m_id[m_act];  f.data = m_data[m_act];  f.dlc = m_dlc[m_act];
    exp_frames.push_back(f);
    repeat (delay) tick();
    tx_ready = 1'b1;
    if (abort_same) mb_abort = 4'(1 << m_act);
    m_abort_l = abort_same;
    tick();
    tx_ready = 1'b0;  mb_abort = '0;
    check("tx_valid_drop_after_accept", tx_valid, 0);
  endtask

  task automatic issue_abort();
    bit ok;
    wait_valid(ok);
    if (!ok) return;
    m_act = m_winner();
    check("active_mb_in_issue", active_mb, m_act);
    mb_abort = 4'(1 << m_act);
    push_pulse('0, '0, 4'(1 << m_act));
    tick();
    mb_abort = '0;
    m_pend[m_act] = 1'b0;
    check("tx_valid_after_issue_abort", tx_valid, 0);
    check("pending_after_issue_abort", mb_pending, m_pend_vec());
  endtask

  task automatic active_abort();
    mb_abort  = 4'(1 << m_act);
    m_abort_l = 1'b1;
    tick();
    mb_abort = '0;
    check("pending_after_wait_abort", mb_pending, m_pend_vec());
  endtask

  task automatic side_abort(input int i);
    mb_abort = 4'(1 << i);
    push_pulse('0, '0, 4'(1 << i));
    tick();
    mb_abort  = '0;
    m_pend[i] = 1'b0;
    check("pending_after_side_abort", mb_pending, m_pend_vec());
  endtask

  task automatic give_result(input logic [1:0] code);
    logic [3:0] one;
    one = 4'(1 << m_act);
    tx_result_valid = 1'b1;  tx_result = code;
    if (code == 2'b00) begin
      push_pulse(one, '0, '0);
      m_pend[m_act] = 1'b0;
    end else if (m_abort_l) begin
      push_pulse('0, '0, one);
      m_pend[m_act] = 1'b0;
    end else if (code != 2'b01) begin
      m_rc[m_act]++;
      if (m_rc[m_act] == MAXR) begin
        push_pulse('0, one, '0);
        m_pend[m_act] = 1'b0;
      end
    end
    m_abort_l = 1'b0;
    tick();
    tx_result_valid = 1'b0;  tx_result = '0;
    check("pending_after_result", mb_pending, m_pend_vec());
  endtask

  task automatic drain();
    int guard = 0;
    while (m_pend_vec() != 0 && !stuck && guard < 100) begin
      guard++;
      handshake($urandom_range(0, 2), 1'b0);
      if (stuck) break;
      give_result(2'b00);
    end
  endtask

  // Monitor: compares every accepted frame and every pulse cycle against the queues.
  always @(negedge clk_can) begin : monitor
    frame_t f;
    pulse_t p;
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        if (exp_frames.size() == 0) begin
          check("frame_unexpected", tx_valid, 0);
        end else begin
          f = exp_frames.pop_front();
          check("frame_active_mb", active_mb, f.idx);
          check("frame_id", tx_id, f.id);
          check("frame_data", tx_data, f.data);
          check("frame_dlc", tx_dlc, f.dlc);
        end
      end
      if ((mb_done | mb_fail | mb_aborted) != '0) begin
        if (exp_pulses.size() == 0) begin
          check("pulse_unexpected", {mb_done, mb_fail, mb_aborted}, 0);
        end else begin
          p = exp_pulses.pop_front();
          check("pulse_cycle", cyc, p.cyc);
          check("pulse_done", mb_done, p.done);
          check("pulse_fail", mb_fail, p.fail);
          check("pulse_aborted", mb_aborted, p.abrt);
        end
      end
    end
  end

  initial begin
    logic [3:0] req;
    logic [3:0] abt;
    logic [1:0] code;
    int         sel;
    int         guard;

    rst_n = 1'b0;  mb_req = '0;  mb_abort = '0;  mb_id = '0;  mb_data = '0;  mb_dlc = '0;
    tx_ready = 1'b0;  tx_result_valid = 1'b0;  tx_result = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      m_pend[i] = 1'b0;  m_rc[i] = 0;  m_id[i] = '0;  m_data[i] = '0;  m_dlc[i] = '0;
    end
    m_act = 0;  m_abort_l = 1'b0;

    repeat (3) tick();
    check("reset_tx_valid", tx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_pending", mb_pending, 0);
    check("reset_tx_id", tx_id, 0);
    check("reset_active_mb", active_mb, 0);
    check("reset_pulses", {mb_done, mb_fail, mb_aborted}, 0);
    rst_n = 1'b1;
    tick();

    // Single mailbox, tx_ready tied high: tx_valid rises three cycles after the request.
    begin
      frame_t f;
      load_mb(2, 32'h123, 64'h0123_4567_89ab_cdef, 4'd8);
      tx_ready = 1'b1;
      m_pend[2] = 1'b1;  m_rc[2] = 0;  m_act = 2;
      f.idx = 2;  f.id = 32'h123;  f.data = 64'h0123_4567_89ab_cdef;  f.dlc = 4'd8;
      exp_frames.push_back(f);
      mb_req = 4'b0100;
      tick();
      mb_req = '0;
      check("lat_pending", mb_pending, 4'b0100);
      check("lat_valid_c1", tx_valid, 0);
      tick();
      check("lat_valid_c2", tx_valid, 0);
      tick();
      check("lat_valid_c3", tx_valid, 1);
      check("lat_active_mb", active_mb, 2);
      check("lat_tx_id", tx_id, 32'h123);
      tick();
      tx_ready = 1'b0;
      check("lat_valid_after_accept", tx_valid, 0);
      m_abort_l = 1'b0;
      give_result(2'b00);
      tick();
      check("lat_done_single_cycle", mb_done, 0);
    end

    // Priority with a tie: expected order 1, 3, 0.
    load_mb(0, 32'h300, 64'hA0, 4'd1);
    load_mb(1, 32'h100, 64'hA1, 4'd2);
    load_mb(3, 32'h100, 64'hA3, 4'd3);
    request(4'b1011, 4'b0000);
    drain();

    // Arbitration lost; a higher-priority request arriving meanwhile is served first.
    load_mb(0, 32'h200, 64'hB0, 4'd4);
    request(4'b0001, 4'b0000);
    handshake(1, 1'b0);
    load_mb(1, 32'h050, 64'hB1, 4'd5);
    request(4'b0010, 4'b0000);
    give_result(2'b01);
    drain();

    // Retry limit: three bus errors then mb_fail, and no fourth issue.
    load_mb(3, 32'h010, 64'hC3, 4'd6);
    request(4'b1000, 4'b0000);
    handshake(0, 1'b0);  give_result(2'b10);
    handshake(0, 1'b0);  give_result(2'b11);
    handshake(0, 1'b0);  give_result(2'b10);
    repeat (4) tick();
    check("retry_no_reissue", tx_valid, 0);
    check("retry_idle", busy, 0);

    // Abort while offered with tx_ready low.
    load_mb(2, 32'h040, 64'hD2, 4'd7);
    request(4'b0100, 4'b0000);
    issue_abort();
    check("issue_abort_idle", busy, 0);

    // Abort during WAIT_RESULT then ok: done only.
    load_mb(1, 32'h060, 64'hE1, 4'd2);
    request(4'b0010, 4'b0000);
    handshake(0, 1'b0);
    active_abort();
    give_result(2'b00);

    // Request and abort together on an idle mailbox: nothing happens.
    request(4'b0001, 4'b0001);
    repeat (3) tick();
    check("req_abort_same_busy", busy, 0);

    // Randomised rounds.
    for (int r = 0; r < 40 && !stuck; r++) begin
      for (int i = 0; i < NUM_MB; i++)
        if (!m_pend[i])
          load_mb(i, 32'($urandom_range(0, 7) * 16), {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      req = 4'($urandom_range(1, 15));
      abt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      request(req, abt);
      guard = 0;
      while (m_pend_vec() != 0 && !stuck && guard < 100) begin
        guard++;
        if ($urandom_range(0, 9) == 0) begin
          issue_abort();
          continue;
        end
        handshake($urandom_range(0, 2), $urandom_range(0, 9) == 0);
        if (stuck) break;
        repeat ($urandom_range(0, 2)) tick();
        sel = $urandom_range(0, NUM_MB - 1);
        if ($urandom_range(0, 2) == 0 && !m_pend[sel]) begin
          load_mb(sel, 32'($urandom_range(0, 7) * 16), {$urandom, $urandom}, 4'($urandom_range(0, 15)));
          request(4'(1 << sel), 4'b0000);
        end
        sel = $urandom_range(0, NUM_MB - 1);
        if ($urandom_range(0, 4) == 0 && m_pend[sel] && sel != m_act) side_abort(sel);
        if (!m_abort_l && $urandom_range(0, 6) == 0) active_abort();
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: code = 2'b00;
          5, 6:          code = 2'b01;
          7, 8:          code = 2'b10;
          default:       code = 2'b11;
        endcase
        give_result(code);
      end
      repeat (3) tick();
      check("round_idle_busy", busy, 0);
      check("round_idle_pending", mb_pending, m_pend_vec());
    end

    // Reset during WAIT_RESULT, then a stale result after release.
    if (!stuck) begin
      load_mb(0, 32'h070, 64'hF0, 4'd3);
      request(4'b0001, 4'b0000);
      handshake(0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx_valid", tx_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_pending", mb_pending, 0);
      check("rst_mid_tx_id", tx_id, 0);
      check("rst_mid_active_mb", active_mb, 0);
      check("rst_mid_pulses", {mb_done, mb_fail, mb_aborted}, 0);
      for (int i = 0; i < NUM_MB; i++) begin
        m_pend[i] = 1'b0;
        m_rc[i]   = 0;
      end
      m_abort_l = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tx_result_valid = 1'b1;  tx_result = 2'b00;
      tick();
      tx_result_valid = 1'b0;
      tick();
      check("stale_result_done", mb_done, 0);
      check("stale_result_busy", busy, 0);
      check("stale_result_pending", mb_pending, 0);
    end

    repeat (4) tick();
    check("frames_left", exp_frames.size(), 0);
    check("pulses_left", exp_pulses.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
